// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI transmit scheduler.
//   state_e : scheduler state encoding (RST_PULSE, IDLE, WAIT_DONE, GAP)
//   clog2   : ceiling log2, used to size index and counter fields
package spi_sched_pkg;

  typedef enum logic [1:0] {
    RST_PULSE = 2'd0,
    IDLE      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  // Number of bits needed to hold the values 0 .. n-1 (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after rr_ptr_i, wrapping modulo NREQ.
// Ports:
//   req_valid_i  in   NREQ  pending request per requester
//   rr_ptr_i     in   IW    index with highest priority this round
//   any_valid_o  out  1     at least one request is pending
//   grant_o      out  IW    selected requester (0 when none pending)
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic            any_valid_o,
  output logic [IW-1:0]   grant_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan offsets from farthest to nearest so the request closest to the
  // pointer is the one left standing after the loop.
  always_comb begin
    any_valid_o = 1'b0;
    grant_o     = '0;
    sum         = '0;
    idx         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      idx = sum[IW-1:0];
      if (req_valid_i[idx]) begin
        any_valid_o = 1'b1;
        grant_o     = idx;
      end
    end
  end

endmodule

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler sharing one SPI transmit master between NREQ
// requesters. Grants one requester at a time, issues a single-cycle dv with
// its word, waits for spi_done, enforces an idle gap, and pulses spi_rst
// after system reset and after a frame timeout.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_valid    in   NREQ     requester i has a word pending (held until ready)
//   req_data     in   NREQ*DW  requester i word at [i*DW +: DW]
//   req_ready    out  NREQ     one-hot pulse: word of requester i accepted
//   tx_data      out  DW       word to SPI master, holds last granted word
//   dv           out  1        pulse: tx_data valid, start frame
//   spi_done     in   1        pulse from SPI master: frame finished
//   spi_rst      out  1        reset pulse to SPI master
//   grant_id     out  IW       index of last granted requester
//   timeout_err  out  1        pulse: frame aborted on timeout
module spi_tx_sched
  import spi_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DW         = 16,
  parameter int RST_CYCLES = 1,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 3000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [DW-1:0]          tx_data,
  output logic                   dv,
  input  logic                   spi_done,
  output logic                   spi_rst,
  output logic [clog2(NREQ)-1:0] grant_id,
  output logic                   timeout_err
);

  localparam int IW = clog2(NREQ);

  // One counter serves the timeout, reset-pulse and gap phases, so it is
  // sized for the longest of them.
  localparam int CNT_MAX = (TIMEOUT >= RST_CYCLES && TIMEOUT >= GAP_CYCLES) ? TIMEOUT :
                           (RST_CYCLES >= GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int CW = clog2(CNT_MAX);

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [DW-1:0]     tx_data_q;
  logic              dv_q;
  logic              spi_rst_q;
  logic [IW-1:0]     grant_id_q;
  logic              timeout_err_q;

  logic              any_valid;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     rr_ptr_d;
  logic [DW-1:0]     word_d;
  logic [NREQ-1:0]   ready_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (any_valid),
    .grant_o     (grant)
  );

  always_comb begin
    rr_ptr_d = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
    ready_d  = NREQ'(1) << grant;
    word_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) begin
        word_d = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RST_PULSE;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      req_ready_q   <= '0;
      tx_data_q     <= '0;
      dv_q          <= 1'b0;
      spi_rst_q     <= 1'b0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      dv_q          <= 1'b0;
      req_ready_q   <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        // spi_rst is already high when arriving from a timeout; after system
        // reset it is raised here first, so the pulse is RST_CYCLES long in
        // both cases.
        RST_PULSE: begin
          if (!spi_rst_q) begin
            spi_rst_q <= 1'b1;
            cnt_q     <= '0;
          end else if (cnt_q == RST_LAST) begin
            spi_rst_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (any_valid) begin
            tx_data_q   <= word_d;
            dv_q        <= 1'b1;
            req_ready_q <= ready_d;
            grant_id_q  <= grant;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= '0;
            state_q     <= WAIT_DONE;
          end
        end
        // spi_done is tested before the timeout so a done arriving on the
        // last allowed cycle still completes the frame normally.
        WAIT_DONE: begin
          if (spi_done) begin
            cnt_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            spi_rst_q     <= 1'b1;
            cnt_q         <= '0;
            state_q       <= RST_PULSE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign dv          = dv_q;
  assign spi_rst     = spi_rst_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_tx_sched.sv
module tb_spi_tx_sched;

  localparam int NREQ       = 4;
  localparam int DW         = 16;
  localparam int RST_CYCLES = 1;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 3000;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     tx_data;
  logic              dv;
  logic              spi_done;
  logic              spi_rst;
  logic [1:0]        grant_id;
  logic              timeout_err;

  always #5 clk = ~clk;

  spi_tx_sched #(
    .NREQ       (NREQ),
    .DW         (DW),
    .RST_CYCLES (RST_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .dv          (dv),
    .spi_done    (spi_done),
    .spi_rst     (spi_rst),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending requests, their words, round-robin pointer.
  logic [NREQ-1:0] pending;
  logic [DW-1:0]   words [NREQ];
  int              model_ptr;

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    req_valid = pending;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = words[i];
  endtask

  task automatic add_random();
    for (int i = 0; i < NREQ; i++) begin
      if (!pending[i] && $urandom_range(0, 3) == 0) begin
        pending[i] = 1'b1;
        words[i]   = DW'($urandom);
      end
    end
  endtask

  // Leaves the DUT in its first IDLE cycle with the pointer at 0.
  task automatic do_reset();
    reset = 1'b1; spi_done = 1'b0; pending = '0; drive_reqs();
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    model_ptr = 0;
  endtask

  // Pulses spi_done in the current cycle and waits out the gap; ends in IDLE.
  task automatic finish_frame();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    repeat (GAP_CYCLES) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_done = 1'b0;
    for (int i = 0; i < NREQ; i++) words[i] = DW'($urandom);
    pending = 4'b0001; drive_reqs();
    tick(); tick();
    n_tests++;
    if ({spi_rst, dv, timeout_err, req_ready, grant_id, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got spi_rst=%0b dv=%0b terr=%0b ready=%b gid=%0d tx=%h, expected all zero",
               spi_rst, dv, timeout_err, req_ready, grant_id, tx_data);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (spi_rst !== 1'b1 || dv !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL rst_pulse: got spi_rst=%0b dv=%0b ready=%b, expected 1 0 0000", spi_rst, dv, req_ready);
    end
    tick();
    n_tests++;
    if (spi_rst !== 1'b0 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_width: got spi_rst=%0b dv=%0b, expected 0 0", spi_rst, dv);
    end
    tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || tx_data !== words[0]) begin
      n_fail++;
      $display("FAIL first_grant: got dv=%0b gid=%0d ready=%b tx=%h, expected 1 0 0001 %h",
               dv, grant_id, req_ready, tx_data, words[0]);
    end
    model_ptr = 1;
    pending = '0; drive_reqs();
    finish_frame();
  endtask

  task automatic test_single();
    pending = 4'b0100; words[2] = 16'h0BB8;
    words[0] = DW'($urandom); words[1] = DW'($urandom); words[3] = DW'($urandom);
    drive_reqs();
    tick();
    n_tests++;
    if (dv !== 1'b1) begin n_fail++; $display("FAIL single_dv: got %0b expected 1", dv); end
    n_tests++;
    if (tx_data !== 16'h0BB8) begin n_fail++; $display("FAIL single_tx: got %h expected 0bb8", tx_data); end
    n_tests++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    n_tests++;
    if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d expected 2", grant_id); end
    pending = '0; drive_reqs();
    tick();
    n_tests++;
    if (dv !== 1'b0 || req_ready !== '0 || tx_data !== 16'h0BB8) begin
      n_fail++;
      $display("FAIL single_pulse: got dv=%0b ready=%b tx=%h, expected 0 0000 0bb8", dv, req_ready, tx_data);
    end
    model_ptr = 3;
    finish_frame();
  endtask

  task automatic test_back_to_back();
    int exp;
    logic [DW-1:0] held;
    do_reset();
    pending = '1;
    for (int i = 0; i < NREQ; i++) words[i] = DW'($urandom);
    drive_reqs();
    tick();
    for (int g = 0; g < 5; g++) begin
      exp = rr_pick(pending, model_ptr);
      n_tests++;
      if (dv !== 1'b1 || int'(grant_id) != exp || grant_id !== 2'(g % NREQ) ||
          req_ready !== (NREQ'(1) << exp) || tx_data !== words[exp]) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got dv=%0b gid=%0d ready=%b tx=%h, expected 1 %0d %b %h",
                 g, dv, grant_id, req_ready, tx_data, exp, NREQ'(1) << exp, words[exp]);
      end
      held = words[exp];
      model_ptr = (exp + 1) % NREQ;
      words[exp] = DW'($urandom);
      if (g == 4) pending = '0;
      drive_reqs();
      if (g < 4) begin
        for (int j = 1; j <= 13; j++) begin
          tick();
          if (j == 11) spi_done = 1'b0;
          n_tests++;
          if (dv !== 1'b0 || req_ready !== '0 || tx_data !== held) begin
            n_fail++;
            $display("FAIL b2b_hold%0d_%0d: got dv=%0b ready=%b tx=%h, expected 0 0000 %h",
                     g, j, dv, req_ready, tx_data, held);
          end
          if (j == 10) spi_done = 1'b1;
        end
        tick();
      end
    end
    finish_frame();
  endtask

  task automatic test_timeout();
    logic bad;
    pending = 4'b0010; words[1] = DW'($urandom); drive_reqs();
    tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL to_grant: got dv=%0b gid=%0d, expected 1 1", dv, grant_id);
    end
    pending = 4'b1000; words[3] = DW'($urandom); drive_reqs();
    model_ptr = 2;
    bad = 1'b0;
    for (int j = 1; j < TIMEOUT; j++) begin
      tick();
      if (timeout_err !== 1'b0 || spi_rst !== 1'b0 || dv !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL to_early: got activity before timeout=%0b, expected 0", bad); end
    tick();
    n_tests++;
    if (timeout_err !== 1'b1 || spi_rst !== 1'b1 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fire: got terr=%0b spi_rst=%0b dv=%0b, expected 1 1 0", timeout_err, spi_rst, dv);
    end
    tick();
    n_tests++;
    if (timeout_err !== 1'b0 || spi_rst !== 1'b0 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL to_after: got terr=%0b spi_rst=%0b dv=%0b, expected 0 0 0", timeout_err, spi_rst, dv);
    end
    tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b1000 || tx_data !== words[3]) begin
      n_fail++;
      $display("FAIL to_regrant: got dv=%0b gid=%0d ready=%b tx=%h, expected 1 3 1000 %h",
               dv, grant_id, req_ready, tx_data, words[3]);
    end
    model_ptr = 0;
    pending = '0; drive_reqs();
    finish_frame();
  endtask

  task automatic test_reset_mid_frame();
    pending = 4'b0100; words[2] = DW'($urandom); drive_reqs();
    tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_grant: got dv=%0b gid=%0d, expected 1 2", dv, grant_id);
    end
    pending = '0; drive_reqs();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({spi_rst, dv, timeout_err, req_ready, grant_id, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got spi_rst=%0b dv=%0b terr=%0b ready=%b gid=%0d tx=%h, expected all zero",
               spi_rst, dv, timeout_err, req_ready, grant_id, tx_data);
    end
    reset = 1'b0;
    pending = 4'b1001; words[0] = DW'($urandom); words[3] = DW'($urandom); drive_reqs();
    tick(); tick(); tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_first: got dv=%0b gid=%0d ready=%b terr=%0b, expected 1 0 0001 0",
               dv, grant_id, req_ready, timeout_err);
    end
    model_ptr = 1;
    pending = '0; drive_reqs();
    finish_frame();
  endtask

  task automatic test_done_handling();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    tick();
    n_tests++;
    if (dv !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done: got dv=%0b terr=%0b, expected 0 0", dv, timeout_err);
    end
    pending = 4'b0010; words[1] = DW'($urandom); drive_reqs();
    tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL idle_done_grant: got dv=%0b gid=%0d, expected 1 1", dv, grant_id);
    end
    pending = '0; drive_reqs();
    model_ptr = 2;
    for (int j = 1; j < TIMEOUT; j++) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0 || spi_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL late_done: got terr=%0b spi_rst=%0b, expected 0 0", timeout_err, spi_rst);
    end
    pending = 4'b0100; words[2] = DW'($urandom); drive_reqs();
    tick();
    n_tests++;
    if (dv !== 1'b0) begin n_fail++; $display("FAIL late_gap1: got dv=%0b expected 0", dv); end
    tick();
    n_tests++;
    if (dv !== 1'b0) begin n_fail++; $display("FAIL late_gap2: got dv=%0b expected 0", dv); end
    tick();
    n_tests++;
    if (dv !== 1'b1 || grant_id !== 2'd2 || tx_data !== words[2]) begin
      n_fail++;
      $display("FAIL late_regrant: got dv=%0b gid=%0d tx=%h, expected 1 2 %h", dv, grant_id, tx_data, words[2]);
    end
    model_ptr = 3;
    pending = '0; drive_reqs();
    finish_frame();
  endtask

  task automatic test_random();
    int exp;
    int d;
    logic [DW-1:0] held;
    logic [NREQ-1:0] m;
    pending = '0; drive_reqs();
    for (int it = 0; it < 40; it++) begin
      if (pending == '0) begin
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom_range(1, 3);
          for (int j = 0; j < d; j++) begin
            tick();
            n_tests++;
            if (dv !== 1'b0) begin n_fail++; $display("FAIL rnd_idle%0d: got dv=%0b expected 0", it, dv); end
          end
        end
        m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) begin
          if (m[i]) begin pending[i] = 1'b1; words[i] = DW'($urandom); end
        end
      end
      drive_reqs();
      tick();
      exp = rr_pick(pending, model_ptr);
      n_tests++;
      if (dv !== 1'b1 || int'(grant_id) != exp || req_ready !== (NREQ'(1) << exp) || tx_data !== words[exp]) begin
        n_fail++;
        $display("FAIL rnd_grant%0d: got dv=%0b gid=%0d ready=%b tx=%h, expected 1 %0d %b %h",
                 it, dv, grant_id, req_ready, tx_data, exp, NREQ'(1) << exp, words[exp]);
      end
      held = words[exp];
      pending[exp] = 1'b0;
      model_ptr = (exp + 1) % NREQ;
      add_random(); drive_reqs();
      d = $urandom_range(0, 15);
      for (int j = 1; j <= d; j++) begin
        tick();
        n_tests++;
        if (dv !== 1'b0 || req_ready !== '0 || tx_data !== held) begin
          n_fail++;
          $display("FAIL rnd_wait%0d: got dv=%0b ready=%b tx=%h, expected 0 0000 %h", it, dv, req_ready, tx_data, held);
        end
        add_random(); drive_reqs();
      end
      spi_done = 1'b1;
      for (int j = 1; j <= GAP_CYCLES + 1; j++) begin
        tick();
        if (j == 1) spi_done = 1'b0;
        n_tests++;
        if (dv !== 1'b0 || req_ready !== '0 || timeout_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_gap%0d: got dv=%0b ready=%b terr=%0b, expected 0 0000 0", it, dv, req_ready, timeout_err);
        end
        add_random(); drive_reqs();
      end
    end
    pending = '0; drive_reqs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; spi_done = 1'b0; req_valid = '0; req_data = '0; pending = '0; model_ptr = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_done_handling();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
